wrr_arbiter_core: RTL and testbench

//  Parametrised weighted round-robin arbiter for NUM_REQ requesters. It is the DUT core

---
 rtl/wrr_arbiter_core.sv | 121 ++++++++++++
 tb/tb_wrr_arbiter_core.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/wrr_arbiter_core.sv
// rtl/wrr_arbiter_core.sv - weighted round-robin arbiter with registered one-hot grant
//
// Ports:
//   clk          single clock, all state on posedge
//   rst          synchronous active-high reset
//   req          request vector, bit i = requester i
//   ack          consumer accepts the current grant this cycle
//   weight_cfg   weight of requester i at [i*WEIGHT_W +: WEIGHT_W]; 0 masks it
//   grant        one-hot grant, 0 when idle
//   grant_valid  a grant is being presented
//   grant_id     index of the granted requester
//   grant_last   current grant uses the last credit of this turn
module wrr_arbiter_core #(
   parameter int NUM_REQ  = 32,
   parameter int WEIGHT_W = 4,
   parameter int ID_W     = $clog2(NUM_REQ)
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [NUM_REQ-1:0]           req,
   input  logic                         ack,
   input  logic [NUM_REQ*WEIGHT_W-1:0]  weight_cfg,
   output logic [NUM_REQ-1:0]           grant,
   output logic                         grant_valid,
   output logic [ID_W-1:0]              grant_id,
   output logic                         grant_last
);

   typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

   state_t                r_state;
   logic [NUM_REQ-1:0]    r_grant;
   logic [ID_W-1:0]       r_id;
   logic [ID_W-1:0]       r_ptr;
   logic [WEIGHT_W-1:0]   r_credits;

   logic [WEIGHT_W-1:0]   w_weight [NUM_REQ];
   logic [NUM_REQ-1:0]    w_elig;
   logic [ID_W-1:0]       w_next_ptr;
   logic [ID_W-1:0]       w_start;
   logic [ID_W-1:0]       w_idx;
   logic [ID_W-1:0]       w_win;
   logic                  w_found;
   logic                  w_continue;

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_elig
      assign w_weight[i] = weight_cfg[i*WEIGHT_W +: WEIGHT_W];
      assign w_elig[i]   = req[i] && (w_weight[i] != '0);
   end

   // Pointer the next turn starts from once the current grant's turn ends.
   assign w_next_ptr = (r_id == ID_W'(NUM_REQ - 1)) ? '0 : r_id + ID_W'(1);

   // While granting, the only winner ever consumed is the one for the next turn,
   // so a single scanner serves both the idle issue and the zero-bubble handover.
   assign w_start = (r_state == GRANT) ? w_next_ptr : r_ptr;

   always_comb begin
      w_found = 1'b0;
      w_win   = '0;
      w_idx   = w_start;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!w_found && w_elig[w_idx]) begin
            w_found = 1'b1;
            w_win   = w_idx;
         end
         w_idx = (w_idx == ID_W'(NUM_REQ - 1)) ? '0 : w_idx + ID_W'(1);
      end
   end

   assign w_continue = (r_credits > WEIGHT_W'(1)) && req[r_id];

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= IDLE;
         r_grant   <= '0;
         r_id      <= '0;
         r_ptr     <= '0;
         r_credits <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_found) begin
                  r_state   <= GRANT;
                  r_id      <= w_win;
                  r_grant   <= NUM_REQ'(1) << w_win;
                  r_credits <= w_weight[w_win];
               end
            end
            GRANT: begin
               if (ack) begin
                  if (w_continue) begin
                     r_credits <= r_credits - WEIGHT_W'(1);
                  end else begin
                     r_ptr <= w_next_ptr;
                     if (w_found) begin
                        r_id      <= w_win;
                        r_grant   <= NUM_REQ'(1) << w_win;
                        r_credits <= w_weight[w_win];
                     end else begin
                        // grant_id keeps its last value while idle.
                        r_state <= IDLE;
                        r_grant <= '0;
                     end
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign grant       = r_grant;
   assign grant_valid = (r_state == GRANT);
   assign grant_id    = r_id;
   assign grant_last  = grant_valid && ((r_credits == WEIGHT_W'(1)) || !req[r_id]);

   a_grant_onehot: assert property (@(posedge clk)
      grant_valid ? $onehot(grant) : (grant == '0));

endmodule

// File: tb/tb_wrr_arbiter_core.sv
// tb/tb_wrr_arbiter_core.sv - scoreboard bench for wrr_arbiter_core (NUM_REQ=4, WEIGHT_W=4)
module tb_wrr_arbiter_core;

   localparam int NUM_REQ  = 4;
   localparam int WEIGHT_W = 4;
   localparam int ID_W     = 2;

   logic                         clk = 1'b0;
   logic                         rst;
   logic [NUM_REQ-1:0]           req;
   logic                         ack;
   logic [NUM_REQ*WEIGHT_W-1:0]  weight_cfg;
   logic [NUM_REQ-1:0]           grant;
   logic                         grant_valid;
   logic [ID_W-1:0]              grant_id;
   logic                         grant_last;

   typedef struct {
      string       tag;
      logic        v;
      logic [1:0]  id;
      logic        last;
   } exp_t;

   exp_t q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   wrr_arbiter_core #(
      .NUM_REQ  (NUM_REQ),
      .WEIGHT_W (WEIGHT_W)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .req         (req),
      .ack         (ack),
      .weight_cfg  (weight_cfg),
      .grant       (grant),
      .grant_valid (grant_valid),
      .grant_id    (grant_id),
      .grant_last  (grant_last)
   );

   always #5 clk = ~clk;

   // Monitor: every negedge with a pending expectation compares the presented outputs.
   always @(negedge clk) begin
      if (q.size() > 0) begin
         exp_t e;
         logic [NUM_REQ-1:0] eg;
         e  = q.pop_front();
         eg = e.v ? (4'b0001 << e.id) : 4'b0000;
         n_cmp++;
         if (grant_valid !== e.v) begin
            n_bad++;
            $display("FAIL %s grant_valid got %b want %b", e.tag, grant_valid, e.v);
         end
         n_cmp++;
         if (grant_id !== e.id) begin
            n_bad++;
            $display("FAIL %s grant_id got %0d want %0d", e.tag, grant_id, e.id);
         end
         n_cmp++;
         if (grant_last !== e.last) begin
            n_bad++;
            $display("FAIL %s grant_last got %b want %b", e.tag, grant_last, e.last);
         end
         n_cmp++;
         if (grant !== eg) begin
            n_bad++;
            $display("FAIL %s grant got %b want %b", e.tag, grant, eg);
         end
      end
   end

   // One clock cycle: drive inputs just after posedge, optionally queue the
   // outputs expected at this cycle's negedge.
   task automatic step(input string tag, input logic i_rst, input logic [3:0] i_req,
                       input logic i_ack, input logic [15:0] i_w, input logic chk,
                       input logic ev, input logic [1:0] eid, input logic elast);
      exp_t e;
      @(posedge clk);
      #1;
      rst        = i_rst;
      req        = i_req;
      ack        = i_ack;
      weight_cfg = i_w;
      if (chk) begin
         e.tag  = tag;
         e.v    = ev;
         e.id   = eid;
         e.last = elast;
         q.push_back(e);
      end
   endtask

   initial begin
      rst        = 1'b1;
      req        = 4'b1111;
      ack        = 1'b1;
      weight_cfg = 16'h1321;

      // T1: reset held 3 cycles with requests pending, then one cycle after.
      step("t1_rst0", 1, 4'b1111, 1, 16'h1321, 1, 0, 0, 0);
      step("t1_rst1", 1, 4'b1010, 1, 16'h1321, 1, 0, 0, 0);
      step("t1_rst2", 1, 4'b1111, 0, 16'h1321, 1, 0, 0, 0);
      // T2: weights {1,2,3,1}, all requesting, ack always.
      step("t1_after", 0, 4'b1111, 1, 16'h1321, 1, 0, 0, 0);
      step("t2_b0",  0, 4'b1111, 1, 16'h1321, 1, 1, 0, 1);
      step("t2_b1",  0, 4'b1111, 1, 16'h1321, 1, 1, 1, 0);
      step("t2_b2",  0, 4'b1111, 1, 16'h1321, 1, 1, 1, 1);
      step("t2_b3",  0, 4'b1111, 1, 16'h1321, 1, 1, 2, 0);
      step("t2_b4",  0, 4'b1111, 1, 16'h1321, 1, 1, 2, 0);
      step("t2_b5",  0, 4'b1111, 1, 16'h1321, 1, 1, 2, 1);
      step("t2_b6",  0, 4'b1111, 1, 16'h1321, 1, 1, 3, 1);
      step("t2_b7",  0, 4'b1111, 1, 16'h1321, 1, 1, 0, 1);
      step("t2_b8",  0, 4'b1111, 1, 16'h1321, 1, 1, 1, 0);
      step("t2_b9",  0, 4'b1111, 1, 16'h1321, 1, 1, 1, 1);

      // T3: single requester 2, weight 2 -> back-to-back turns, no bubble.
      step("t3_rst", 1, 4'b0100, 1, 16'h0200, 0, 0, 0, 0);
      step("t3_c0",  0, 4'b0100, 1, 16'h0200, 1, 0, 0, 0);
      step("t3_c1",  0, 4'b0100, 1, 16'h0200, 1, 1, 2, 0);
      step("t3_c2",  0, 4'b0100, 1, 16'h0200, 1, 1, 2, 1);
      step("t3_c3",  0, 4'b0100, 1, 16'h0200, 1, 1, 2, 0);
      step("t3_c4",  0, 4'b0100, 1, 16'h0200, 1, 1, 2, 1);
      step("t3_c5",  0, 4'b0100, 1, 16'h0200, 1, 1, 2, 0);

      // T4: weights {2,0,1,1}; zero-weight requester masked, then only id 0 wins.
      step("t4_rst", 1, 4'b0010, 1, 16'h1102, 0, 0, 0, 0);
      step("t4_c0",  0, 4'b0010, 1, 16'h1102, 1, 0, 0, 0);
      step("t4_c1",  0, 4'b0010, 1, 16'h1102, 1, 0, 0, 0);
      step("t4_c2",  0, 4'b0010, 1, 16'h1102, 1, 0, 0, 0);
      step("t4_c3",  0, 4'b0011, 1, 16'h1102, 1, 0, 0, 0);
      step("t4_c4",  0, 4'b0011, 1, 16'h1102, 1, 1, 0, 0);
      step("t4_c5",  0, 4'b0011, 1, 16'h1102, 1, 1, 0, 1);
      step("t4_c6",  0, 4'b0011, 1, 16'h1102, 1, 1, 0, 0);
      step("t4_c7",  0, 4'b0011, 1, 16'h1102, 1, 1, 0, 1);
      step("t4_drop", 0, 4'b0000, 1, 16'h1102, 1, 1, 0, 1);
      step("t4_idle", 0, 4'b0000, 1, 16'h1102, 1, 0, 0, 0);

      // T5: requester 2 weight 3, ack held low 5 cycles, then full burst.
      step("t5_rst", 1, 4'b0100, 0, 16'h0300, 0, 0, 0, 0);
      step("t5_c0",  0, 4'b0100, 0, 16'h0300, 1, 0, 0, 0);
      for (int i = 0; i < 5; i++)
         step("t5_hold", 0, 4'b0100, 0, 16'h0300, 1, 1, 2, 0);
      step("t5_a0",  0, 4'b0100, 1, 16'h0300, 1, 1, 2, 0);
      step("t5_a1",  0, 4'b0100, 1, 16'h0300, 1, 1, 2, 0);
      step("t5_a2",  0, 4'b0100, 1, 16'h0300, 1, 1, 2, 1);
      step("t5_a3",  0, 4'b0100, 1, 16'h0300, 1, 1, 2, 0);

      // T6: weight[0]=3, req[0] drops after first ack; then reset mid-burst of id 3.
      step("t6_rst", 1, 4'b1001, 1, 16'h2003, 0, 0, 0, 0);
      step("t6_c0",  0, 4'b1001, 1, 16'h2003, 1, 0, 0, 0);
      step("t6_c1",  0, 4'b1001, 1, 16'h2003, 1, 1, 0, 0);
      step("t6_c2",  0, 4'b1000, 1, 16'h2003, 1, 1, 0, 1);
      step("t6_c3",  0, 4'b1001, 1, 16'h2003, 1, 1, 3, 0);
      step("t6_mid", 1, 4'b1001, 1, 16'h2003, 1, 1, 3, 1);
      step("t6_post", 0, 4'b1001, 1, 16'h2003, 1, 0, 0, 0);
      step("t6_ptr0", 0, 4'b1001, 1, 16'h2003, 1, 1, 0, 0);

      @(posedge clk);
      @(negedge clk);
      n_cmp++;
      if (q.size() != 0) begin
         n_bad++;
         $display("FAIL sb_drain pending got %0d want 0", q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
